adju_dac_tx: RTL and testbench



---
 rtl/adju_pkg.sv | 22 ++
 rtl/adju_dac_conv.sv | 46 ++++
 rtl/sumador.sv | 12 +
 rtl/adju_dac_tx.sv | 130 +++++++++++++
 tb/tb_adju_dac_tx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/adju_pkg.sv
// Shared constants, state encoding and frame packing for the ADC/DAC adjust
// blocks.
package adju_pkg;

  localparam int ADC_OFFSET = 8192;
  localparam int DAC_BITS   = 12;
  localparam int DAC_MAX    = 4095;
  localparam int FRAME_BITS = 16;
  localparam logic [1:0] PD_NORMAL = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_t;

  // DAC121S101 frame: two don't-care bits, power-down mode, 12-bit code.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DAC_BITS-1:0] code);
    return {2'b00, PD_NORMAL, code};
  endfunction

endpackage

// File: rtl/adju_dac_conv.sv
// Filter sample -> 12-bit offset-binary DAC code (undo x4, remove offset, clamp).
// DAC_ROUND_EN selects round-half-up instead of truncation.
module adju_dac_conv
  import adju_pkg::*;
#(
  parameter int N = 23
) (
  input  logic signed [N-1:0]   i_x,
  output logic [DAC_BITS-1:0]   o_code,
  output logic                  o_sat
);

  logic signed [N:0] w_x_ext;
  logic signed [N:0] w_offset;
  logic signed [N:0] w_sum;
  logic signed [N:0] w_shift;

  assign w_x_ext = {i_x[N-1], i_x};

`ifdef DAC_ROUND_EN
  assign w_offset = (N+1)'(ADC_OFFSET + 2);
`else
  assign w_offset = (N+1)'(ADC_OFFSET);
`endif

  Sumador #(.W(N+1)) u_sum (
    .i_a (w_x_ext),
    .i_b (w_offset),
    .o_s (w_sum)
  );

  assign w_shift = w_sum >>> 2;

  always_comb begin
    o_code = w_shift[DAC_BITS-1:0];
    o_sat  = 1'b0;
    if (w_sum[N]) begin
      o_code = '0;
      o_sat  = 1'b1;
    end else if (w_shift > (N+1)'(DAC_MAX)) begin
      o_code = DAC_BITS'(DAC_MAX);
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/sumador.sv
// Generic two's-complement adder shared by the adjust stages.
module Sumador #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_s
);

  assign o_s = i_a + i_b;

endmodule

// File: rtl/adju_dac_tx.sv
// Converts one filter sample per accept and shifts it to a DAC121S101-class DAC
// over SPI (SYNC/SCLK/DIN). Optional macro: DAC_ROUND_EN (round instead of truncate).
module adju_dac_tx
  import adju_pkg::*;
#(
  parameter int N       = 23,
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [N-1:0] salidafiltro,
  input  logic                dato_valido,
  output logic                listo,
  output logic                saturado,
  output logic                dac_sync,
  output logic                dac_sclk,
  output logic                dac_din
);

  localparam int CW = $clog2(2*CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2*CLK_DIV - 1);
  localparam logic [4:0]    HALF_LAST = 5'(2*FRAME_BITS - 1);

  dac_state_t            r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [4:0]            r_half, w_half_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic                  r_sync, w_sync_nxt;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_listo, r_sat, w_sat_nxt;
  logic [DAC_BITS-1:0]   w_code;
  logic                  w_conv_sat;
  logic                  w_accept;

  adju_dac_conv #(.N(N)) u_conv (
    .i_x    (salidafiltro),
    .o_code (w_code),
    .o_sat  (w_conv_sat)
  );

  assign w_accept = dato_valido && r_listo;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_half_nxt  = r_half;
    w_shift_nxt = r_shift;
    w_sync_nxt  = r_sync;
    w_sclk_nxt  = r_sclk;
    w_sat_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_half_nxt  = '0;
          w_shift_nxt = make_frame(w_code);
          w_sync_nxt  = 1'b0;
          w_sclk_nxt  = 1'b1;
          w_sat_nxt   = w_conv_sat;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt_nxt  = '0;
          w_half_nxt = r_half + 5'd1;
          w_sclk_nxt = ~r_sclk;
          // Odd half-period ends on an SCLK rise: advance to the next bit or finish.
          if (r_half[0]) begin
            if (r_half == HALF_LAST) begin
              w_state_nxt = ST_GAP;
              w_sync_nxt  = 1'b1;
              w_sclk_nxt  = 1'b1;
              w_shift_nxt = '0;
            end else begin
              w_shift_nxt = r_shift << 1;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_sync_nxt  = 1'b1;
        w_sclk_nxt  = 1'b1;
        w_shift_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
      r_shift <= '0;
      r_sync  <= 1'b1;
      r_sclk  <= 1'b1;
      r_listo <= 1'b1;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_shift <= w_shift_nxt;
      r_sync  <= w_sync_nxt;
      r_sclk  <= w_sclk_nxt;
      r_listo <= (w_state_nxt == ST_IDLE);
      r_sat   <= w_sat_nxt;
    end
  end

  assign listo    = r_listo;
  assign saturado = r_sat;
  assign dac_sync = r_sync;
  assign dac_sclk = r_sclk;
  assign dac_din  = r_shift[FRAME_BITS-1];

endmodule

// File: tb/tb_adju_dac_tx.sv
// Bench for adju_dac_tx: vector table, randomized samples against an arithmetic
// model of the DAC mapping, and SPI frame capture on SCLK falling edges.
module tb_adju_dac_tx;

  localparam int N = 23;
  localparam int CLK_DIV = 4;
  localparam int SYNC_LOW = 32*CLK_DIV;
  localparam int LISTO_LAT = 34*CLK_DIV + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [N-1:0] salidafiltro = '0;
  logic dato_valido = 1'b0;
  logic listo, saturado, dac_sync, dac_sclk, dac_din;

  int n_chk = 0;
  int n_pass = 0;

  adju_dac_tx #(.N(N), .CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .salidafiltro (salidafiltro),
    .dato_valido  (dato_valido),
    .listo        (listo),
    .saturado     (saturado),
    .dac_sync     (dac_sync),
    .dac_sclk     (dac_sclk),
    .dac_din      (dac_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    else n_pass++;
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: DAC code = (x + 8192 [+2]) / 4, clamped to [0, 4095].
  function automatic void ref_model(input int x, output int code, output int sat);
    int s;
`ifdef DAC_ROUND_EN
    s = x + 8192 + 2;
`else
    s = x + 8192;
`endif
    sat = 0;
    if (s < 0) begin
      code = 0;
      sat = 1;
    end else begin
      code = s / 4;
      if (code > 4095) begin
        code = 4095;
        sat = 1;
      end
    end
  endfunction

  task automatic wait_listo(input string name);
    int n;
    n = 0;
    while (listo !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (listo !== 1'b1) timeout(name);
  endtask

  // Accept one sample and capture the resulting SPI frame.
  task automatic do_frame(input int x, input bit poke_mid, output logic [15:0] frame,
                          output int sat, output int sync_low, output int listo_lat, output int bits);
    logic prev_sclk;
    int n;
    wait_listo("wait_listo");
    salidafiltro = N'(x);
    dato_valido = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dato_valido = 1'b0;
    salidafiltro = N'(x ^ 32'h155);
    sat = int'(saturado);
    chk("listo_low_after_accept", listo, 0);
    frame = '0;
    bits = 0;
    sync_low = 0;
    listo_lat = 0;
    prev_sclk = dac_sclk;
    n = 1;
    if (dac_sync == 1'b0) sync_low++;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (poke_mid && n == 40) begin
        salidafiltro = N'(-x - 777);
        dato_valido = 1'b1;
      end else if (poke_mid && n == 42) begin
        dato_valido = 1'b0;
      end
      if (dac_sync == 1'b0) sync_low++;
      if (prev_sclk == 1'b1 && dac_sclk == 1'b0 && dac_sync == 1'b0) begin
        frame = {frame[14:0], dac_din};
        bits++;
      end
      prev_sclk = dac_sclk;
      if (listo == 1'b1) begin
        listo_lat = n;
        break;
      end
    end
    if (listo_lat == 0) timeout("frame_end");
  endtask

  typedef struct {
    int x;
    int code;
    int sat;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [15:0] frame;
    int sat, sync_low, listo_lat, bits, ecode, esat;
    int starts[$];
    logic prev_sync;
    bit idle_ok;

    vecs.push_back('{0, 12'h800, 0});
    vecs.push_back('{-8192, 12'h000, 0});
    vecs.push_back('{-9000, 12'h000, 1});
    vecs.push_back('{8188, 12'hFFF, 0});
    vecs.push_back('{20000, 12'hFFF, 1});
    vecs.push_back('{-4194304, 12'h000, 1});
    vecs.push_back('{4194303, 12'hFFF, 1});
    vecs.push_back('{-4, 12'h7FF, 0});
`ifdef DAC_ROUND_EN
    vecs.push_back('{2, 12'h801, 0});
    vecs.push_back('{8190, 12'hFFF, 1});
`else
    vecs.push_back('{2, 12'h800, 0});
    vecs.push_back('{8190, 12'hFFF, 0});
`endif

    // Reset state and idle hold
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (listo !== 1'b1 || dac_sync !== 1'b1 || dac_sclk !== 1'b1 || dac_din !== 1'b0 || saturado !== 1'b0)
        idle_ok = 1'b0;
    end
    chk("rst_listo", listo, 1);
    chk("rst_saturado", saturado, 0);
    chk("rst_sync", dac_sync, 1);
    chk("rst_sclk", dac_sclk, 1);
    chk("rst_din", dac_din, 0);
    chk("idle_hold", idle_ok, 1);

    // Vector table
    foreach (vecs[i]) begin
      do_frame(vecs[i].x, 1'b0, frame, sat, sync_low, listo_lat, bits);
      chk($sformatf("vec%0d_frame", i), frame, {4'b0000, 12'(vecs[i].code)});
      chk($sformatf("vec%0d_sat", i), sat, vecs[i].sat);
      chk($sformatf("vec%0d_bits", i), bits, 16);
      chk($sformatf("vec%0d_sync_low", i), sync_low, SYNC_LOW);
      chk($sformatf("vec%0d_listo_lat", i), listo_lat, LISTO_LAT);
    end

    // Randomized samples against the model
    for (int i = 0; i < 20; i++) begin
      int x;
      x = int'($urandom_range(0, 60000)) - 30000;
      ref_model(x, ecode, esat);
      do_frame(x, 1'b0, frame, sat, sync_low, listo_lat, bits);
      chk($sformatf("rnd%0d_frame", i), frame, {4'b0000, 12'(ecode)});
      chk($sformatf("rnd%0d_sat", i), sat, esat);
    end

    // dato_valido pulsed mid-frame with a different sample is ignored
    ref_model(1000, ecode, esat);
    do_frame(1000, 1'b1, frame, sat, sync_low, listo_lat, bits);
    chk("midpoke_frame", frame, {4'b0000, 12'(ecode)});
    chk("midpoke_sync_low", sync_low, SYNC_LOW);
    chk("midpoke_listo_lat", listo_lat, LISTO_LAT);
    @(negedge clk);
    chk("midpoke_no_new_frame", dac_sync, 1);

    // Back-to-back: dato_valido held high
    wait_listo("b2b_wait");
    salidafiltro = N'(100);
    dato_valido = 1'b1;
    prev_sync = dac_sync;
    for (int c = 0; c < 600 && starts.size() < 3; c++) begin
      @(negedge clk);
      if (prev_sync == 1'b1 && dac_sync == 1'b0) starts.push_back(c);
      prev_sync = dac_sync;
    end
    dato_valido = 1'b0;
    if (starts.size() < 3) timeout("b2b_starts");
    else begin
      chk("b2b_spacing0", starts[1] - starts[0], LISTO_LAT);
      chk("b2b_spacing1", starts[2] - starts[1], LISTO_LAT);
    end

    // Reset mid-frame (around bit 7) aborts asynchronously
    wait_listo("rst_mid_wait");
    salidafiltro = N'(5000);
    dato_valido = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dato_valido = 1'b0;
    repeat (15*CLK_DIV) @(negedge clk);
    chk("pre_rst_sync_low", dac_sync, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_sync", dac_sync, 1);
    chk("midrst_sclk", dac_sclk, 1);
    chk("midrst_listo", listo, 1);
    chk("midrst_din", dac_din, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ref_model(-3000, ecode, esat);
    do_frame(-3000, 1'b0, frame, sat, sync_low, listo_lat, bits);
    chk("postrst_frame", frame, {4'b0000, 12'(ecode)});
    chk("postrst_bits", bits, 16);
    chk("postrst_sync_low", sync_low, SYNC_LOW);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
